// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared types and constants for the serial pattern detector.
//   - seq_state_e : control FSM state (FILL while the history is still
//                   filling, ARMED once LEN bits are present)
//   - LEN_MIN/MAX : legal range of the pattern length
//   - fill_w()    : width of a counter that must hold 0..len
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } seq_state_e;

  localparam int LEN_MIN = 2;
  localparam int LEN_MAX = 16;

  function automatic int fill_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/seq_det_shreg.sv
// seq_det_shreg
//   LEN-bit history shift register with a saturating fill counter.
//   The shift-path next values are exported combinationally so the
//   parent can compare against the post-shift contents on the same
//   edge that accepts the bit.
//
// Ports
//   clk_i       in   clock, rising edge
//   rst_i       in   synchronous active-high reset
//   en_i        in   accept bit_i this cycle (shift + count)
//   bit_i       in   serial data bit, enters at the LSB
//   clr_fill_i  in   clear the fill counter (wins over en_i for the count)
//   hist_nxt_o  out  history as it will be after shifting bit_i in
//   fill_nxt_o  out  fill count after accepting bit_i (saturates at LEN)
//   fill_o      out  current fill count
module seq_det_shreg
  import seq_det_pkg::*;
#(
  parameter int LEN = 4,
  parameter int FW  = fill_w(LEN)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          bit_i,
  input  logic          clr_fill_i,
  output logic [LEN-1:0] hist_nxt_o,
  output logic [FW-1:0]  fill_nxt_o,
  output logic [FW-1:0]  fill_o
);

  logic [LEN-1:0] hist_q;
  logic [FW-1:0]  fill_q;

  // fill_nxt_o deliberately ignores clr_fill_i: the parent derives the
  // clear from a compare on these outputs, so folding it in would loop.
  always_comb begin
    hist_nxt_o = {hist_q[LEN-2:0], bit_i};
    fill_nxt_o = (fill_q == FW'(LEN)) ? fill_q : fill_q + FW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      if (en_i) begin
        hist_q <= hist_nxt_o;
      end
      if (clr_fill_i) begin
        fill_q <= '0;
      end else if (en_i) begin
        fill_q <= fill_nxt_o;
      end
    end
  end

  assign fill_o = fill_q;

endmodule

// File: rtl/seq_det_param.sv
// seq_det_param
//   Serial pattern detector with a run-time loadable LEN-bit pattern.
//   y pulses for one cycle on the edge that accepts the bit completing
//   a match. The history is only considered once LEN bits have been
//   accepted since reset, pattern load or (non-overlapping) last match.
//
//   Build option: define SEQ_DET_COUNT_EN to add a saturating match
//   counter and its match_cnt port; without it the port is absent.
//
// Ports
//   clk1       in   clock, rising edge
//   rst        in   synchronous active-high reset (highest priority)
//   i          in   serial data bit
//   i_valid    in   i is accepted only when high
//   pat_load   in   capture pat_in as the active pattern (beats i_valid)
//   pat_in     in   LEN-bit pattern, MSB is the oldest bit
//   match_cnt  out  saturating count of y pulses (SEQ_DET_COUNT_EN only)
//   y          out  registered one-cycle match pulse
//
// FSM states
//   state | meaning
//   FILL  | fewer than LEN bits accepted since last clear; no match possible
//   ARMED | LEN bits present; every accepted bit is compared
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1011,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input  logic           clk1,
  input  logic           rst,
  input  logic           i,
  input  logic           i_valid,
  input  logic           pat_load,
  input  logic [LEN-1:0] pat_in,
`ifdef SEQ_DET_COUNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic           y
);

  localparam int FW = fill_w(LEN);

  if (LEN < LEN_MIN || LEN > LEN_MAX) begin : g_bad_len
    $error("seq_det_param: LEN=%0d outside %0d..%0d", LEN, LEN_MIN, LEN_MAX);
  end

  if (OVERLAP != 0 && OVERLAP != 1) begin : g_bad_overlap
    $error("seq_det_param: OVERLAP=%0d must be 0 or 1", OVERLAP);
  end

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("seq_det_param: CNT_W=%0d must be at least 1", CNT_W);
  end

  seq_state_e     state_q, state_d;
  logic [LEN-1:0] pat_q, pat_d;
  logic           y_q, y_d;

  logic           accept;
  logic           full_nxt;
  logic           match;
  logic           drop_fill;
  logic           clr_fill;
  logic [LEN-1:0] hist_nxt;
  logic [FW-1:0]  fill_nxt;
  logic [FW-1:0]  fill_q;

  // A pattern load discards any bit presented in the same cycle.
  assign accept    = i_valid && !pat_load;
  assign full_nxt  = (fill_nxt == FW'(LEN));
  assign match     = accept && full_nxt && (hist_nxt == pat_q);
  assign drop_fill = match && (OVERLAP == 0);
  assign clr_fill  = pat_load || drop_fill;

  seq_det_shreg #(
    .LEN (LEN),
    .FW  (FW)
  ) u_shreg (
    .clk_i      (clk1),
    .rst_i      (rst),
    .en_i       (accept),
    .bit_i      (i),
    .clr_fill_i (clr_fill),
    .hist_nxt_o (hist_nxt),
    .fill_nxt_o (fill_nxt),
    .fill_o     (fill_q)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    y_d     = match;

    if (pat_load) begin
      pat_d = pat_in;
    end

    case (state_q)
      FILL: begin
        // A non-overlapping match on the LEN-th bit empties the history
        // again, so the FSM never reaches ARMED in that case.
        if (accept && full_nxt && !drop_fill) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (pat_load || drop_fill) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q <= FILL;
      pat_q   <= PATTERN;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      y_q     <= y_d;
    end
  end

  assign y = y_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

  a_state_tracks_fill: assert property (
    @(posedge clk1) disable iff (rst)
    (state_q == ARMED) == (fill_q == FW'(LEN))
  );

endmodule

// File: tb/tb_seq_det_param.sv
// tb_seq_det_param
//   Two detectors (overlapping and non-overlapping) share one stimulus
//   stream. The reference model keeps the bits accepted since the last
//   clear in a queue and declares a match when the newest LEN of them
//   spell the active pattern. Expected y per cycle (and expected count
//   per pulse) are queued at stimulus time and popped by a monitor.
module tb_seq_det_param;

  localparam int             LEN     = 4;
  localparam logic [LEN-1:0] PAT     = 4'b1011;
  localparam int             CNT_W   = 8;
  localparam int             CNT_MAX = (1 << CNT_W) - 1;

  logic           clk1     = 1'b0;
  logic           rst      = 1'b1;
  logic           i        = 1'b0;
  logic           i_valid  = 1'b0;
  logic           pat_load = 1'b0;
  logic [LEN-1:0] pat_in   = '0;
  logic           y_ov, y_no;
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_ov, cnt_no;
`endif

  int checks = 0;
  int errors = 0;
  int pulses_ov = 0;
  int pulses_no = 0;

  bit exp_y_ov[$];
  bit exp_y_no[$];
  int exp_c_ov[$];
  int exp_c_no[$];

  bit             hist_ov[$];
  bit             hist_no[$];
  logic [LEN-1:0] pat_m = PAT;
  int             cnt_m_ov = 0;
  int             cnt_m_no = 0;
  bit             mon_e;

  always #5 clk1 = ~clk1;

  seq_det_param #(
    .LEN(LEN), .PATTERN(PAT), .OVERLAP(1), .CNT_W(CNT_W)
  ) dut_ov (
    .clk1(clk1), .rst(rst), .i(i), .i_valid(i_valid),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_COUNT_EN
    .match_cnt(cnt_ov),
`endif
    .y(y_ov)
  );

  seq_det_param #(
    .LEN(LEN), .PATTERN(PAT), .OVERLAP(0), .CNT_W(CNT_W)
  ) dut_no (
    .clk1(clk1), .rst(rst), .i(i), .i_valid(i_valid),
    .pat_load(pat_load), .pat_in(pat_in),
`ifdef SEQ_DET_COUNT_EN
    .match_cnt(cnt_no),
`endif
    .y(y_no)
  );

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input bit exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One accepted bit through the model of one detector.
  task automatic model_bit(input bit ov, input bit b, output bit m);
    bit             h[$];
    logic [LEN-1:0] w;
    if (ov) h = hist_ov;
    else    h = hist_no;
    h.push_back(b);
    if (h.size() > LEN) void'(h.pop_front());
    w = '0;
    foreach (h[k]) w = {w[LEN-2:0], h[k]};
    m = (h.size() == LEN) && (w == pat_m);
    if (ov) begin
      hist_ov = h;
      if (m && cnt_m_ov < CNT_MAX) cnt_m_ov++;
    end else begin
      if (m) h.delete();
      hist_no = h;
      if (m && cnt_m_no < CNT_MAX) cnt_m_no++;
    end
  endtask

  task automatic step(input bit r, input bit v, input bit b, input bit pl,
                      input logic [LEN-1:0] pin);
    bit e_ov, e_no;
    @(negedge clk1);
    rst = r; i_valid = v; i = b; pat_load = pl; pat_in = pin;
    e_ov = 1'b0;
    e_no = 1'b0;
    if (r) begin
      hist_ov.delete(); hist_no.delete();
      pat_m = PAT; cnt_m_ov = 0; cnt_m_no = 0;
    end else if (pl) begin
      pat_m = pin;
      hist_ov.delete(); hist_no.delete();
    end else if (v) begin
      model_bit(1'b1, b, e_ov);
      model_bit(1'b0, b, e_no);
    end
    exp_y_ov.push_back(e_ov);
    exp_y_no.push_back(e_no);
    if (e_ov) exp_c_ov.push_back(cnt_m_ov);
    if (e_no) exp_c_no.push_back(cnt_m_no);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
    logic [15:0] v;
    v = bits;
    for (int k = n - 1; k >= 0; k--) begin
      step(1'b0, 1'b1, v[k], 1'b0, '0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, $urandom_range(0, 1), 1'b0, '0);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic clear_pulses();
    pulses_ov = 0;
    pulses_no = 0;
  endtask

  always begin
    @(posedge clk1);
    #1;
    if (exp_y_ov.size() != 0) begin
      mon_e = exp_y_ov.pop_front();
      check_bit("y_ov", y_ov, mon_e);
      if (y_ov === 1'b1) pulses_ov++;
`ifdef SEQ_DET_COUNT_EN
      if (mon_e && exp_c_ov.size() != 0) check_int("match_cnt_ov", int'(cnt_ov), exp_c_ov.pop_front());
`endif
    end
    if (exp_y_no.size() != 0) begin
      mon_e = exp_y_no.pop_front();
      check_bit("y_no", y_no, mon_e);
      if (y_no === 1'b1) pulses_no++;
`ifdef SEQ_DET_COUNT_EN
      if (mon_e && exp_c_no.size() != 0) check_int("match_cnt_no", int'(cnt_no), exp_c_no.pop_front());
`endif
    end
  end

  initial begin
    // reset state
    do_reset();
`ifdef SEQ_DET_COUNT_EN
    check_int("reset_cnt_ov", int'(cnt_ov), 0);
    check_int("reset_cnt_no", int'(cnt_no), 0);
`endif

    // 1,0,1,1,0,1,1 back to back
    clear_pulses();
    send_bits(16'b1011011, 7, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_int("stream7_pulses_ov", pulses_ov, 2);
    check_int("stream7_pulses_no", pulses_no, 1);
`ifdef SEQ_DET_COUNT_EN
    check_int("stream7_cnt_ov", int'(cnt_ov), 2);
    check_int("stream7_cnt_no", int'(cnt_no), 1);
`endif

    // 1,0,1,1 with 3-cycle valid gaps
    do_reset();
    clear_pulses();
    send_bits(16'b1011, 4, 3);
    check_int("gap_pulses_ov", pulses_ov, 1);
    check_int("gap_pulses_no", pulses_no, 1);

    // all-zero pattern, fill guard, load concurrent with a valid bit
    do_reset();
    clear_pulses();
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    send_bits(16'b0000, 4, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'b0000);
    send_bits(16'b0000, 4, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_int("zero_pat_pulses_ov", pulses_ov, 2);
    check_int("zero_pat_pulses_no", pulses_no, 2);

    // reset mid-stream aborts the partial match
    do_reset();
    clear_pulses();
    send_bits(16'b101, 3, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    send_bits(16'b1, 1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_int("rst_abort_pulses_ov", pulses_ov, 0);
    check_int("rst_abort_pulses_no", pulses_no, 0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 1), $urandom_range(0, 24) == 0,
           LEN'($urandom_range(0, 15)));
    end

    // saturation: 303 ones against 1111
    do_reset();
    clear_pulses();
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111);
    for (int n = 0; n < 303; n++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_int("sat_pulses_ov", pulses_ov, 300);
    check_int("sat_pulses_no", pulses_no, 75);
`ifdef SEQ_DET_COUNT_EN
    check_int("sat_cnt_ov", int'(cnt_ov), 255);
    check_int("sat_cnt_no", int'(cnt_no), 75);
    // a pattern load leaves the count untouched
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_int("load_keeps_cnt_ov", int'(cnt_ov), 255);
`endif

    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk1);
    @(negedge clk1);
    check_int("scoreboard_drained_ov", exp_y_ov.size(), 0);
    check_int("scoreboard_drained_no", exp_y_no.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
